// File: rtl/fp_exception_unit_pkg.sv
// Shared definitions for the FP exception unit: operation codes,
// exception codes and the bit positions of the sticky status flags.
package fp_exception_unit_pkg;

  typedef enum logic [1:0] {
    OP_ADDITION       = 2'b00,
    OP_SUBTRACTION    = 2'b01,
    OP_MULTIPLICATION = 2'b10,
    OP_DIVISION       = 2'b11
  } fp_op_e;

  typedef enum logic [2:0] {
    EXC_NONE     = 3'b000,
    EXC_NAN_IN   = 3'b001,
    EXC_INVALID  = 3'b010,
    EXC_DIV_ZERO = 3'b011,
    EXC_INF_RES  = 3'b100,
    EXC_ZERO_RES = 3'b101
  } fp_exc_e;

  localparam int STICKY_NAN      = 0;
  localparam int STICKY_INVALID  = 1;
  localparam int STICKY_DIV_ZERO = 2;
  localparam int STICKY_ANY      = 3;

  // Sticky-flag contribution of a single classified operation.
  function automatic logic [3:0] sticky_bits(input fp_exc_e code);
    logic [3:0] bits;
    bits                  = '0;
    bits[STICKY_NAN]      = (code == EXC_NAN_IN);
    bits[STICKY_INVALID]  = (code == EXC_INVALID);
    bits[STICKY_DIV_ZERO] = (code == EXC_DIV_ZERO);
    bits[STICKY_ANY]      = (code != EXC_NONE);
    return bits;
  endfunction

endpackage

// File: rtl/fp_exception_unit_if.sv
// Request/result bundle between the issuing stage, the exception unit
// and the downstream FPU datapath. The master drives requests and accepts
// results; the slave is the exception unit itself.
interface fp_exception_unit_if #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       fp_operation;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic             out_valid;
  logic             out_ready;
  logic             op_is_exception;
  logic [2:0]       fp_exce;
  logic [W-1:0]     special_result;
  logic [3:0]       sticky_flags;
  logic [CNT_W-1:0] exc_count;
  logic             clr_sticky;

  modport master (
    output in_valid, fp_operation, op_a, op_b, out_ready, clr_sticky,
    input  in_ready, out_valid, op_is_exception, fp_exce, special_result,
           sticky_flags, exc_count
  );

  modport slave (
    input  in_valid, fp_operation, op_a, op_b, out_ready, clr_sticky,
    output in_ready, out_valid, op_is_exception, fp_exce, special_result,
           sticky_flags, exc_count
  );

endinterface

// File: rtl/fp_exception_unit_classify.sv
// Combinational classification of one {sign, exp, man} operand.
// Subnormals (exp 0, man != 0) count as finite nonzero values.
module fp_classify #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 is_nan,
  output logic                 is_inf,
  output logic                 is_zero,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign {sign, exp_f, man_f} = op;
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  assign is_nan  = exp_ones && !man_zero;
  assign is_inf  = exp_ones && man_zero;
  assign is_zero = exp_zero && man_zero;

endmodule

// File: rtl/fp_exception_unit.sv
// Front-end exception screen for the FPU. Classifies both operands,
// picks the highest-priority exception, builds the bypass result and
// registers it behind a one-deep valid/ready stage. Also keeps sticky
// status flags and a saturating exception counter.
module fp_exception_unit
  import fp_exception_unit_pkg::*;
#(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_exception_unit_if.slave bus
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic a_nan, a_inf, a_zero, a_sign;
  logic b_nan, b_inf, b_zero, b_sign;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .op(bus.op_a), .is_nan(a_nan), .is_inf(a_inf), .is_zero(a_zero), .sign(a_sign)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .op(bus.op_b), .is_nan(b_nan), .is_inf(b_inf), .is_zero(b_zero), .sign(b_sign)
  );

  fp_op_e           op;
  fp_exc_e          exc_code;
  logic             invalid;
  logic             res_sign;
  logic [W-1:0]     res_value;
  logic             load;
  logic [3:0]       event_bits;
  logic [3:0]       flags_base;
  logic [CNT_W-1:0] count_base;

  logic             valid_q;
  logic             is_exc_q;
  logic [2:0]       exce_q;
  logic [W-1:0]     result_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] count_q;

  assign op   = fp_op_e'(bus.fp_operation);
  assign load = bus.in_valid && bus.in_ready;

  // Pick the exception code in priority order and the sign of the special result.
  always_comb begin
    invalid  = 1'b0;
    res_sign = a_sign ^ b_sign;
    case (op)
      OP_ADDITION: begin
        invalid  = a_inf && b_inf && (a_sign != b_sign);
        res_sign = a_inf ? a_sign : b_sign;
      end
      OP_SUBTRACTION: begin
        invalid  = a_inf && b_inf && (a_sign == b_sign);
        res_sign = a_inf ? a_sign : ~b_sign;
      end
      OP_MULTIPLICATION: invalid = (a_zero && b_inf) || (a_inf && b_zero);
      OP_DIVISION:       invalid = (a_zero && b_zero) || (a_inf && b_inf);
      default:           invalid = 1'b0;
    endcase

    exc_code = EXC_NONE;
    if (a_nan || b_nan)
      exc_code = EXC_NAN_IN;
    else if (invalid)
      exc_code = EXC_INVALID;
    else if (op == OP_DIVISION && !a_zero && !a_inf && b_zero)
      exc_code = EXC_DIV_ZERO;
    else if ((a_inf || b_inf) && !(op == OP_DIVISION && b_inf))
      exc_code = EXC_INF_RES;
    else if ((op == OP_MULTIPLICATION && (a_zero || b_zero)) ||
             (op == OP_DIVISION && (a_zero || b_inf)))
      exc_code = EXC_ZERO_RES;
  end

  // Build the bypass value: canonical NaN, signed inf, signed zero or all zeros.
  always_comb begin
    res_value = '0;
    case (exc_code)
      EXC_NAN_IN, EXC_INVALID: begin
        res_value[W-2 -: EXP_W] = '1;
        res_value[MAN_W-1]      = 1'b1;
      end
      EXC_DIV_ZERO, EXC_INF_RES: begin
        res_value[W-1]          = res_sign;
        res_value[W-2 -: EXP_W] = '1;
      end
      EXC_ZERO_RES: res_value[W-1] = res_sign;
      default:      res_value = '0;
    endcase
  end

  // A clear takes effect before the event being loaded in the same cycle.
  always_comb begin
    event_bits = load ? sticky_bits(exc_code) : 4'b0000;
    flags_base = bus.clr_sticky ? 4'b0000 : flags_q;
    count_base = bus.clr_sticky ? '0 : count_q;
  end

  // Result stage: load on transfer, drop valid once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      is_exc_q <= 1'b0;
      exce_q   <= 3'b000;
      result_q <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      is_exc_q <= (exc_code != EXC_NONE);
      exce_q   <= exc_code;
      result_q <= res_value;
    end else if (bus.out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  // Sticky flags accumulate and the exception counter saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
      count_q <= '0;
    end else begin
      flags_q <= flags_base | event_bits;
      if (load && exc_code != EXC_NONE && count_base != '1)
        count_q <= count_base + CNT_W'(1);
      else
        count_q <= count_base;
    end
  end

  assign bus.in_ready        = !valid_q || bus.out_ready;
  assign bus.out_valid       = valid_q;
  assign bus.op_is_exception = is_exc_q;
  assign bus.fp_exce         = exce_q;
  assign bus.special_result  = result_q;
  assign bus.sticky_flags    = flags_q;
  assign bus.exc_count       = count_q;

endmodule

// File: tb/tb_fp_exception_unit.sv
// Self-checking bench for fp_exception_unit (FP8 1-4-3 configuration).
// A behavioural model derives expected codes, results, flags and counts
// from operand categories and the handshake rules.
module tb_fp_exception_unit;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int CNT_W = 8;
  localparam int W     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  // model state
  logic       m_valid  = 1'b0;
  logic [2:0] m_code   = 3'd0;
  logic [7:0] m_result = 8'h00;
  int         m_flags  = 0;
  int         m_count  = 0;

  fp_exception_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) bus ();

  fp_exception_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] code;
    logic [7:0] res;
  } vec_t;

  vec_t vecs [12] = '{
    '{0, 8'h78, 8'hF8, 3'd2, 8'h7C},
    '{1, 8'hF8, 8'hF8, 3'd2, 8'h7C},
    '{1, 8'hF8, 8'h78, 3'd4, 8'hF8},
    '{3, 8'hB8, 8'h00, 3'd3, 8'hF8},
    '{2, 8'h00, 8'h78, 3'd2, 8'h7C},
    '{2, 8'h38, 8'h80, 3'd5, 8'h80},
    '{0, 8'h7C, 8'h38, 3'd1, 8'h7C},
    '{0, 8'h38, 8'h38, 3'd0, 8'h00},
    '{3, 8'h78, 8'h00, 3'd4, 8'h78},
    '{3, 8'h38, 8'hF8, 3'd5, 8'h80},
    '{1, 8'h38, 8'hF8, 3'd4, 8'h78},
    '{0, 8'h00, 8'h00, 3'd0, 8'h00}
  };

  // 0 finite nonzero, 1 zero, 2 inf, 3 NaN
  function automatic int category(input logic [7:0] v);
    int e;
    int m;
    e = (int'(v) / 8) % 16;
    m = int'(v) % 8;
    if (e == 15) return (m == 0) ? 2 : 3;
    if (e == 0 && m == 0) return 1;
    return 0;
  endfunction

  function automatic void ref_model(input int op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [2:0] code, output logic [7:0] res);
    int ca;
    int cb;
    int sa;
    int sb;
    int s;
    ca = category(a);
    cb = category(b);
    sa = int'(a) / 128;
    sb = int'(b) / 128;
    code = 3'd0;
    if (ca == 3 || cb == 3) code = 3'd1;
    else if ((op == 0 && ca == 2 && cb == 2 && sa != sb) ||
             (op == 1 && ca == 2 && cb == 2 && sa == sb) ||
             (op == 2 && ((ca == 1 && cb == 2) || (ca == 2 && cb == 1))) ||
             (op == 3 && ((ca == 1 && cb == 1) || (ca == 2 && cb == 2)))) code = 3'd2;
    else if (op == 3 && ca == 0 && cb == 1) code = 3'd3;
    else if ((ca == 2 || cb == 2) && !(op == 3 && cb == 2)) code = 3'd4;
    else if ((op == 2 && (ca == 1 || cb == 1)) || (op == 3 && (ca == 1 || cb == 2))) code = 3'd5;
    if (op >= 2)      s = sa ^ sb;
    else if (op == 0) s = (ca == 2) ? sa : sb;
    else              s = (ca == 2) ? sa : 1 - sb;
    case (code)
      3'd1, 3'd2: res = 8'h7C;
      3'd3, 3'd4: res = 8'(s * 128 + 120);
      3'd5:       res = 8'(s * 128);
      default:    res = 8'h00;
    endcase
  endfunction

  function automatic int event_bits(input logic [2:0] code);
    return (code == 3'd1 ? 1 : 0) + (code == 3'd2 ? 2 : 0) +
           (code == 3'd3 ? 4 : 0) + (code != 3'd0 ? 8 : 0);
  endfunction

  function automatic logic [7:0] rand_operand();
    int k;
    int s;
    int e;
    int m;
    k = $urandom_range(0, 5);
    s = $urandom_range(0, 1);
    case (k)
      0:       begin e = 0;  m = 0; end
      1:       begin e = 15; m = 0; end
      2:       begin e = 15; m = $urandom_range(1, 7); end
      default: begin e = $urandom_range(0, 14); m = $urandom_range(0, 7); end
    endcase
    return 8'(s * 128 + e * 8 + m);
  endfunction

  task automatic drive(input logic v, input int op, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy, input logic clr);
    bus.in_valid     = v;
    bus.fp_operation = 2'(op);
    bus.op_a         = a;
    bus.op_b         = b;
    bus.out_ready    = rdy;
    bus.clr_sticky   = clr;
  endtask

  // Advance the model across the coming rising edge using the inputs just driven.
  task automatic model_step();
    logic       accept;
    logic [2:0] code;
    logic [7:0] res;
    accept = bus.in_valid && (!m_valid || bus.out_ready);
    if (bus.clr_sticky) begin
      m_flags = 0;
      m_count = 0;
    end
    if (accept) begin
      ref_model(int'(bus.fp_operation), bus.op_a, bus.op_b, code, res);
      m_valid  = 1'b1;
      m_code   = code;
      m_result = res;
      m_flags  = m_flags | event_bits(code);
      if (code != 3'd0 && m_count < 255) m_count++;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({bus.out_valid, bus.op_is_exception, bus.fp_exce, bus.special_result,
         bus.sticky_flags, bus.exc_count} !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b e=%b c=%b r=%h f=%b n=%0d, want all 0",
               bus.out_valid, bus.op_is_exception, bus.fp_exce, bus.special_result,
               bus.sticky_flags, bus.exc_count);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      model_step();
      @(negedge clk);
      tests_run++;
      if ({bus.out_valid, bus.fp_exce, bus.special_result, bus.op_is_exception} !==
          {1'b1, vecs[i].code, vecs[i].res, vecs[i].code != 3'd0}) begin
        tests_failed++;
        $display("[TB] FAIL directed[%0d]: got v=%b code=%b res=%h exc=%b, want v=1 code=%b res=%h",
                 i, bus.out_valid, bus.fp_exce, bus.special_result, bus.op_is_exception,
                 vecs[i].code, vecs[i].res);
      end
      tests_run++;
      if (bus.sticky_flags !== 4'(m_flags) || bus.exc_count !== 8'(m_count)) begin
        tests_failed++;
        $display("[TB] FAIL directed_sticky[%0d]: got f=%b n=%0d, want f=%b n=%0d",
                 i, bus.sticky_flags, bus.exc_count, 4'(m_flags), m_count);
      end
      if (i == 0) begin
        tests_run++;
        if (bus.sticky_flags !== 4'b1010 || bus.exc_count !== 8'd1) begin
          tests_failed++;
          $display("[TB] FAIL first_sticky: got f=%b n=%0d, want f=1010 n=1",
                   bus.sticky_flags, bus.exc_count);
        end
      end
      drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
      model_step();
    end
  endtask

  task automatic test_backpressure();
    int count_before;
    @(negedge clk);
    count_before = m_count;
    drive(1'b1, 3, 8'hB8, 8'h00, 1'b0, 1'b0);
    model_step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.out_valid, bus.fp_exce, bus.special_result, bus.in_ready} !==
          {1'b1, 3'd3, 8'hF8, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_hold[%0d]: got v=%b code=%b res=%h rdy=%b, want v=1 code=011 res=f8 rdy=0",
                 i, bus.out_valid, bus.fp_exce, bus.special_result, bus.in_ready);
      end
      drive(1'b1, 2, 8'h38, 8'h80, 1'b0, 1'b0);
      model_step();
    end
    @(negedge clk);
    drive(1'b1, 2, 8'h38, 8'h80, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_release_ready: got %b want 1", bus.in_ready);
    end
    model_step();
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.fp_exce, bus.special_result} !== {1'b1, 3'd5, 8'h80}) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_second: got v=%b code=%b res=%h, want v=1 code=101 res=80",
               bus.out_valid, bus.fp_exce, bus.special_result);
    end
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    model_step();
    @(negedge clk);
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.exc_count !== 8'(count_before + 2)) begin
      tests_failed++;
      $display("[TB] FAIL backpressure_drain: got v=%b n=%0d, want v=0 n=%0d",
               bus.out_valid, bus.exc_count, count_before + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== m_valid ||
          (m_valid && {bus.fp_exce, bus.special_result, bus.op_is_exception} !==
                      {m_code, m_result, m_code != 3'd0})) begin
        tests_failed++;
        $display("[TB] FAIL random_result[%0d]: got v=%b code=%b res=%h exc=%b, want v=%b code=%b res=%h",
                 i, bus.out_valid, bus.fp_exce, bus.special_result, bus.op_is_exception,
                 m_valid, m_code, m_result);
      end
      tests_run++;
      if (bus.sticky_flags !== 4'(m_flags) || bus.exc_count !== 8'(m_count)) begin
        tests_failed++;
        $display("[TB] FAIL random_sticky[%0d]: got f=%b n=%0d, want f=%b n=%0d",
                 i, bus.sticky_flags, bus.exc_count, 4'(m_flags), m_count);
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3), rand_operand(), rand_operand(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      #1;
      tests_run++;
      if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
        tests_failed++;
        $display("[TB] FAIL random_in_ready[%0d]: got %b want %b",
                 i, bus.in_ready, !m_valid || bus.out_ready);
      end
      model_step();
    end
    @(negedge clk);
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    model_step();
  endtask

  task automatic test_clear_saturate();
    @(negedge clk);
    drive(1'b1, 3, 8'hB8, 8'h00, 1'b1, 1'b1);
    model_step();
    @(negedge clk);
    tests_run++;
    if (bus.sticky_flags !== 4'b1100 || bus.exc_count !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL clear_with_load: got f=%b n=%0d, want f=1100 n=1",
               bus.sticky_flags, bus.exc_count);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2, 8'h00, 8'h78, 1'b1, 1'b0);
      model_step();
      @(negedge clk);
    end
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    model_step();
    tests_run++;
    if (bus.exc_count !== 8'd255 || bus.sticky_flags !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL saturate: got f=%b n=%0d, want f=1110 n=255",
               bus.sticky_flags, bus.exc_count);
    end
    @(negedge clk);
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b1);
    model_step();
    @(negedge clk);
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    model_step();
    tests_run++;
    if (bus.exc_count !== 8'd0 || bus.sticky_flags !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL clear_alone: got f=%b n=%0d, want f=0000 n=0",
               bus.sticky_flags, bus.exc_count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 0, 8'h78, 8'hF8, 1'b0, 1'b0);
    model_step();
    @(negedge clk);
    drive(1'b0, 0, 8'h00, 8'h00, 1'b0, 1'b0);
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.fp_exce !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_valid: got v=%b code=%b, want v=1 code=010",
               bus.out_valid, bus.fp_exce);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.op_is_exception, bus.fp_exce, bus.special_result,
         bus.sticky_flags, bus.exc_count} !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got v=%b e=%b c=%b r=%h f=%b n=%0d, want all 0",
               bus.out_valid, bus.op_is_exception, bus.fp_exce, bus.special_result,
               bus.sticky_flags, bus.exc_count);
    end
    m_valid = 1'b0;
    m_flags = 0;
    m_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1, 8'hF8, 8'h78, 1'b1, 1'b0);
    model_step();
    @(negedge clk);
    tests_run++;
    if ({bus.out_valid, bus.fp_exce, bus.special_result, bus.sticky_flags, bus.exc_count} !==
        {1'b1, 3'd4, 8'hF8, 4'b1000, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_request: got v=%b code=%b res=%h f=%b n=%0d, want v=1 code=100 res=f8 f=1000 n=1",
               bus.out_valid, bus.fp_exce, bus.special_result, bus.sticky_flags, bus.exc_count);
    end
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    model_step();
  endtask

  initial begin
    drive(1'b0, 0, 8'h00, 8'h00, 1'b1, 1'b0);
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_clear_saturate();
    test_async_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp_exception_unit.md
Name: fp_exception_unit

Overview:
Parametrised, pipelined successor to the FP8 exception checker. Classifies both operands of an FP operation of any exponent/mantissa width and detects NaN inputs, invalid operations, divide-by-zero and trivially special results. Produces a registered exception code plus the ready-made IEEE-style special result that bypasses the arithmetic datapath. Keeps sticky status flags and a saturating exception counter. Sits in front of the FPU datapath with a valid/ready handshake on both sides.

Parameters:
EXP_W, 4, exponent field width
MAN_W, 3, mantissa field width (operand width W = 1+EXP_W+MAN_W; defaults give FP8 1-4-3)
CNT_W, 8, exception counter width

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
IN_VALID  in  1  operation request valid
IN_READY  out  1  unit can accept a request
FP_OPERATION  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
OP_A  in  W  operand A {sign, exp, man}
OP_B  in  W  operand B
OUT_VALID  out  1  result register holds a valid classification
OUT_READY  in  1  downstream accepts the result
OP_IS_EXCEPTION  out  1  FP_EXCE != 000; datapath result must be replaced by SPECIAL_RESULT
FP_EXCE  out  3  exception code
SPECIAL_RESULT  out  W  bypass result
STICKY_FLAGS  out  4  [0] NaN input, [1] invalid, [2] div-by-zero, [3] any exception
EXC_COUNT  out  CNT_W  saturating count of exceptions
CLR_STICKY  in  1  synchronous clear of STICKY_FLAGS and EXC_COUNT

Behaviour:
- Clocking: one clock (CLK); reset is asynchronous and active-low (RST_N). All outputs reset to 0, including OUT_VALID, OP_IS_EXCEPTION, FP_EXCE, SPECIAL_RESULT, STICKY_FLAGS and EXC_COUNT. Reset asserted mid-transaction discards the pending result immediately.
- Classification: zero = exp 0 and man 0; inf = exp all-ones and man 0; NaN = exp all-ones and man != 0. Subnormals are finite nonzero.
- Codes, in priority order:
  - 001 NAN_IN: either operand NaN.
  - 010 INVALID:
    - ADD: infs of opposite sign.
    - SUB: infs of the same sign (both +inf-+inf and -inf--inf).
    - MUL: zero times inf, either order.
    - DIV: 0/0 or inf/inf.
  - 011 DIV_ZERO: DIV with finite nonzero A and zero B.
  - 100 INF_RESULT: any remaining inf operand, except DIV where B is inf.
  - 101 ZERO_RESULT:
    - MUL with a zero operand.
    - DIV with zero A or inf B.
  - 000 NONE: otherwise; ADD/SUB with zeros is left to the datapath.
- SPECIAL_RESULT:
  - 001/010: canonical NaN {0, all-ones, 1 followed by zeros}.
  - 011/100: inf.
  - 101: zero.
  - 000: all zeros.
- Result sign:
  - MUL/DIV: signA ^ signB.
  - ADD: sign of the inf operand.
  - SUB: signA if A is inf, else ~signB.
- Handshake:
  - Transfer when IN_VALID && IN_READY.
  - IN_READY = !OUT_VALID || OUT_READY.
  - Latency 1 cycle; full throughput when OUT_READY is held high.
  - While OUT_VALID && !OUT_READY, all outputs hold stable.
  - OUT_VALID clears after a transfer with no new input.
- Sticky and counter:
  - Updated on the cycle a result is loaded. Flags are OR-set; EXC_COUNT increments when the code != 000 and saturates at all-ones.
  - CLR_STICKY in the same cycle as a load: clear happens first, then the new event is applied. Resulting flags = new event bits only; count = 1 if the event is an exception, else 0.

Decomposition:
- Shared package (FPU_PACK) gains:
  - Operation codes _ADDITION/_SUBTRACTION/_MULTIPLICATION/_DIVISION.
  - Exception codes _EXC_NONE.._EXC_ZERO_RES.
  - Sticky bit indices.
- One sub-module, fp_classify (parameters EXP_W, MAN_W), combinational. Outputs is_nan, is_inf, is_zero, sign. Instantiated per operand.

Test Plan:
- ADD 0x78 + 0xF8, OUT_READY=1 -> next cycle: OUT_VALID=1, FP_EXCE=010, SPECIAL_RESULT=0x7C, STICKY_FLAGS=1010, EXC_COUNT=1.
- SUB 0xF8 - 0xF8 -> FP_EXCE=010; SUB 0xF8 - 0x78 -> FP_EXCE=100, SPECIAL_RESULT=0xF8.
- DIV 0xB8 / 0x00 -> FP_EXCE=011, SPECIAL_RESULT=0xF8; MUL 0x00 * 0x78 -> FP_EXCE=010. MUL 0x38 * 0x80 -> FP_EXCE=101, SPECIAL_RESULT=0x80. ADD 0x7C + 0x38 -> FP_EXCE=001.
- Backpressure: OUT_READY=0 with back-to-back requests -> first result held stable and IN_READY=0. Raise OUT_READY -> second result appears one cycle after first transfer; no request lost or duplicated.
- CLR_STICKY coincident with a DIV_ZERO load -> STICKY_FLAGS=1100, EXC_COUNT=1. Then 300 exception requests -> EXC_COUNT=255.
- Drop RST_N while OUT_VALID=1 -> OUT_VALID, FP_EXCE, STICKY_FLAGS and EXC_COUNT are 0 without waiting for a CLK edge. After release the first request completes normally.
